// File: rtl/pong_game_ctrl.sv
// Pong game-flow controller: attract screen, serve, rally, point and game-over sequencing.
// Owns both scores and drives the renderer state plus the ball-physics run/recentre controls.
module pong_game_ctrl #(
  parameter int WIN_SCORE    = 11,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 30,
  parameter int OVER_FRAMES  = 120
) (
  input  logic       clk_0,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       any_key,
  input  logic       miss_left,
  input  logic       miss_right,
  output logic [3:0] score_p1,
  output logic [3:0] score_p2,
  output logic       sq_shown,
  output logic       game_over,
  output logic       show_startup,
  output logic       ball_run,
  output logic       ball_reset,
  output logic       serve_dir
);

  typedef enum logic [2:0] {
    ST_ATTRACT,
    ST_SERVE_WAIT,
    ST_PLAY,
    ST_POINT,
    ST_OVER
  } state_t;

  localparam logic [3:0] WIN        = 4'(WIN_SCORE);
  localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
  localparam logic [7:0] POINT_LAST = 8'(POINT_FRAMES - 1);
  localparam logic [7:0] OVER_LIM   = 8'(OVER_FRAMES);

  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       key_q, key_edge;
  logic [3:0] p1_nxt, p2_nxt;
  logic       dir_nxt, entering;
  logic       sq_nxt, over_nxt, startup_nxt, run_nxt, recentre_nxt;

  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    return (s >= WIN) ? WIN : s + 4'd1;
  endfunction

  function automatic logic [7:0] sat_cnt(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  assign key_edge = any_key & ~key_q;

  always_comb begin
    state_nxt = state;
    p1_nxt    = score_p1;
    p2_nxt    = score_p2;
    dir_nxt   = serve_dir;
    case (state)
      ST_ATTRACT:    if (key_edge) state_nxt = ST_SERVE_WAIT;
      ST_SERVE_WAIT: if (frame_tick && cnt == SERVE_LAST) state_nxt = ST_PLAY;
      ST_PLAY: begin
        // A simultaneous double miss credits player 2 only.
        if (miss_left) begin
          p2_nxt    = sat_inc(score_p2);
          dir_nxt   = 1'b0;
          state_nxt = ST_POINT;
        end else if (miss_right) begin
          p1_nxt    = sat_inc(score_p1);
          dir_nxt   = 1'b1;
          state_nxt = ST_POINT;
        end
      end
      ST_POINT: begin
        if (frame_tick && cnt == POINT_LAST)
          state_nxt = (score_p1 == WIN || score_p2 == WIN) ? ST_OVER : ST_SERVE_WAIT;
      end
      ST_OVER: begin
        if (key_edge && cnt >= OVER_LIM) begin
          state_nxt = ST_ATTRACT;
          p1_nxt    = 4'd0;
          p2_nxt    = 4'd0;
          dir_nxt   = 1'b0;
        end
      end
      default: state_nxt = ST_ATTRACT;
    endcase

    entering = (state_nxt != state);
    if (entering)        cnt_nxt = 8'd0;
    else if (frame_tick) cnt_nxt = sat_cnt(cnt);
    else                 cnt_nxt = cnt;

    // Outputs are decoded from the next state so the registers line up with it.
    sq_nxt       = (state_nxt == ST_SERVE_WAIT) || (state_nxt == ST_PLAY);
    over_nxt     = (state_nxt == ST_OVER);
    startup_nxt  = (state_nxt == ST_ATTRACT);
    run_nxt      = (state_nxt == ST_PLAY);
    recentre_nxt = entering && ((state_nxt == ST_SERVE_WAIT) || (state_nxt == ST_POINT));
  end

  always_ff @(posedge clk_0 or posedge rst) begin
    if (rst) begin
      state        <= ST_ATTRACT;
      cnt          <= 8'd0;
      key_q        <= 1'b0;
      score_p1     <= 4'd0;
      score_p2     <= 4'd0;
      serve_dir    <= 1'b0;
      sq_shown     <= 1'b0;
      game_over    <= 1'b0;
      show_startup <= 1'b1;
      ball_run     <= 1'b0;
      ball_reset   <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      key_q        <= any_key;
      score_p1     <= p1_nxt;
      score_p2     <= p2_nxt;
      serve_dir    <= dir_nxt;
      sq_shown     <= sq_nxt;
      game_over    <= over_nxt;
      show_startup <= startup_nxt;
      ball_run     <= run_nxt;
      ball_reset   <= recentre_nxt;
    end
  end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Bench for pong_game_ctrl: two instances (default WIN_SCORE and WIN_SCORE=3) against a
// tick-counting game model, with directed scenarios and a randomized soak.
module tb_pong_game_ctrl;

  localparam int M_ATTRACT = 0, M_SERVE = 1, M_PLAY = 2, M_POINT = 3, M_OVER = 4;
  localparam int SERVE_N = 60, POINT_N = 30, OVER_N = 120;
  localparam logic [13:0] RESET_VEC = 14'h0008;

  logic clk_0 = 1'b0, rst = 1'b1;
  logic frame_tick = 1'b0, any_key = 1'b0, miss_left = 1'b0, miss_right = 1'b0;
  bit   clk_en = 1'b1;

  logic [3:0] a_score_p1, a_score_p2, b_score_p1, b_score_p2;
  logic a_sq_shown, a_game_over, a_show_startup, a_ball_run, a_ball_reset, a_serve_dir;
  logic b_sq_shown, b_game_over, b_show_startup, b_ball_run, b_ball_reset, b_serve_dir;
  logic [13:0] got_a, got_b;

  int total = 0, bad = 0;

  pong_game_ctrl dut0 (
    .clk_0(clk_0), .rst(rst), .frame_tick(frame_tick), .any_key(any_key),
    .miss_left(miss_left), .miss_right(miss_right),
    .score_p1(a_score_p1), .score_p2(a_score_p2), .sq_shown(a_sq_shown),
    .game_over(a_game_over), .show_startup(a_show_startup), .ball_run(a_ball_run),
    .ball_reset(a_ball_reset), .serve_dir(a_serve_dir)
  );

  pong_game_ctrl #(.WIN_SCORE(3)) dut1 (
    .clk_0(clk_0), .rst(rst), .frame_tick(frame_tick), .any_key(any_key),
    .miss_left(miss_left), .miss_right(miss_right),
    .score_p1(b_score_p1), .score_p2(b_score_p2), .sq_shown(b_sq_shown),
    .game_over(b_game_over), .show_startup(b_show_startup), .ball_run(b_ball_run),
    .ball_reset(b_ball_reset), .serve_dir(b_serve_dir)
  );

  assign got_a = {a_score_p1, a_score_p2, a_sq_shown, a_game_over, a_show_startup,
                  a_ball_run, a_ball_reset, a_serve_dir};
  assign got_b = {b_score_p1, b_score_p2, b_sq_shown, b_game_over, b_show_startup,
                  b_ball_run, b_ball_reset, b_serve_dir};

  initial forever begin
    #5;
    if (clk_en) clk_0 = ~clk_0;
  end

  // Game model: phase, ticks seen in the phase, scores, serve side, fresh-entry flag.
  typedef struct {
    int phase;
    int ticks;
    int p1;
    int p2;
    bit dir;
    bit fresh;
    bit kprev;
  } model_t;

  model_t m0, m1;

  function automatic model_t model_reset();
    model_t m;
    m.phase = M_ATTRACT; m.ticks = 0; m.p1 = 0; m.p2 = 0;
    m.dir = 1'b0; m.fresh = 1'b0; m.kprev = 1'b0;
    return m;
  endfunction

  function automatic model_t model_step(model_t m, int win, bit ft, bit key, bit ml, bit mr);
    bit press = key && !m.kprev;
    int nxt = m.phase;
    m.kprev = key;
    m.fresh = 1'b0;
    case (m.phase)
      M_ATTRACT: if (press) nxt = M_SERVE;
      M_SERVE:   if (ft && m.ticks + 1 == SERVE_N) nxt = M_PLAY;
      M_PLAY: begin
        if (ml) begin
          m.p2 = (m.p2 + 1 > win) ? win : m.p2 + 1; m.dir = 1'b0; nxt = M_POINT;
        end else if (mr) begin
          m.p1 = (m.p1 + 1 > win) ? win : m.p1 + 1; m.dir = 1'b1; nxt = M_POINT;
        end
      end
      M_POINT: if (ft && m.ticks + 1 == POINT_N) nxt = (m.p1 == win || m.p2 == win) ? M_OVER : M_SERVE;
      M_OVER: if (press && m.ticks >= OVER_N) begin
        nxt = M_ATTRACT; m.p1 = 0; m.p2 = 0; m.dir = 1'b0;
      end
      default: nxt = M_ATTRACT;
    endcase
    if (nxt != m.phase) begin
      m.phase = nxt;
      m.ticks = 0;
      m.fresh = (nxt == M_SERVE) || (nxt == M_POINT);
    end else if (ft) begin
      m.ticks++;
    end
    return m;
  endfunction

  function automatic logic [13:0] exp_vec(model_t m);
    return {4'(m.p1), 4'(m.p2), 1'(m.phase == M_SERVE || m.phase == M_PLAY), 1'(m.phase == M_OVER),
            1'(m.phase == M_ATTRACT), 1'(m.phase == M_PLAY), m.fresh, m.dir};
  endfunction

  always @(posedge clk_0 or posedge rst) begin
    if (rst) begin
      m0 = model_reset();
      m1 = model_reset();
    end else begin
      m0 = model_step(m0, 11, frame_tick, any_key, miss_left, miss_right);
      m1 = model_step(m1, 3, frame_tick, any_key, miss_left, miss_right);
    end
  end

  task automatic cycle(input bit ft, input bit key, input bit ml, input bit mr);
    frame_tick = ft; any_key = key; miss_left = ml; miss_right = mr;
    @(posedge clk_0);
    @(negedge clk_0);
    frame_tick = 1'b0; miss_left = 1'b0; miss_right = 1'b0;
  endtask

  task automatic run_to_play();
    for (int i = 0; i < 400 && !a_ball_run; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk_0);
    total++;
    if (got_a !== RESET_VEC || got_b !== RESET_VEC) begin
      bad++; $display("FAIL reset_state: dut0=%h dut1=%h expected=%h", got_a, got_b, RESET_VEC);
    end
    rst = 1'b0;
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    total++;
    if ({got_a, got_b} !== {exp_vec(m0), exp_vec(m1)}) begin
      bad++; $display("FAIL reset_idle: dut0=%h dut1=%h expected=%h/%h", got_a, got_b, exp_vec(m0), exp_vec(m1));
    end
  endtask

  task automatic test_key_hold();
    int ticks_sent = 0, pulses = 0;
    bit seen_run = 1'b0, ft;
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    total++;
    if (a_sq_shown !== 1'b1 || a_ball_reset !== 1'b1 || a_show_startup !== 1'b0) begin
      bad++; $display("FAIL key_enter: sq/reset/startup=%b%b%b expected=110", a_sq_shown, a_ball_reset, a_show_startup);
    end
    pulses = 1;
    for (int i = 0; i < 499; i++) begin
      ft = ($urandom_range(0, 1) == 0) || (i % 4 == 0);
      if (ft && !a_ball_run) ticks_sent++;
      cycle(ft, 1'b1, 1'b0, 1'b0);
      total++;
      if ({got_a, got_b} !== {exp_vec(m0), exp_vec(m1)}) begin
        bad++; $display("FAIL key_hold: dut0=%h dut1=%h expected=%h/%h", got_a, got_b, exp_vec(m0), exp_vec(m1));
      end
      pulses += int'(a_ball_reset);
      if (a_ball_run && !seen_run) begin
        seen_run = 1'b1;
        total++;
        if (ticks_sent != SERVE_N) begin
          bad++; $display("FAIL serve_ticks: run after %0d ticks expected=%0d", ticks_sent, SERVE_N);
        end
      end
    end
    total++;
    if (pulses != 1 || a_ball_run !== 1'b1) begin
      bad++; $display("FAIL key_hold_once: pulses=%0d run=%b expected 1/1", pulses, a_ball_run);
    end
  endtask

  task automatic test_miss_left();
    int n = 0;
    bit ft;
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    total++;
    if ({a_score_p2, a_serve_dir, a_sq_shown, a_ball_reset} !== {4'd1, 1'b0, 1'b0, 1'b1}) begin
      bad++; $display("FAIL miss_left: p2/dir/sq/rst=%h/%b%b%b expected 1/001", a_score_p2, a_serve_dir, a_sq_shown, a_ball_reset);
    end
    for (int i = 0; i < 300 && n < POINT_N; i++) begin
      ft = ($urandom_range(0, 2) == 0);
      n += int'(ft);
      cycle(ft, 1'b0, 1'b0, 1'b0);
      total++;
      if ({got_a, got_b} !== {exp_vec(m0), exp_vec(m1)}) begin
        bad++; $display("FAIL point_wait: dut0=%h dut1=%h expected=%h/%h", got_a, got_b, exp_vec(m0), exp_vec(m1));
      end
    end
    total++;
    if (a_sq_shown !== 1'b1 || a_ball_reset !== 1'b1 || a_ball_run !== 1'b0) begin
      bad++; $display("FAIL point_to_serve: sq/rst/run=%b%b%b expected=110", a_sq_shown, a_ball_reset, a_ball_run);
    end
    run_to_play();
  endtask

  task automatic test_both_miss();
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    total++;
    if (a_score_p2 !== 4'd2 || a_score_p1 !== 4'd0 || a_serve_dir !== 1'b0) begin
      bad++; $display("FAIL both_miss: p1=%0d p2=%0d dir=%b expected p1=0 p2=2 dir=0", a_score_p1, a_score_p2, a_serve_dir);
    end
    for (int i = 0; i < POINT_N; i++) begin
      cycle(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      total++;
      if ({got_a, got_b} !== {exp_vec(m0), exp_vec(m1)} || a_score_p1 !== 4'd0 || a_score_p2 !== 4'd2) begin
        bad++; $display("FAIL miss_in_point: dut0=%h dut1=%h expected=%h/%h", got_a, got_b, exp_vec(m0), exp_vec(m1));
      end
    end
    run_to_play();
  endtask

  task automatic test_win3();
    for (int k = 0; k < 3; k++) begin
      run_to_play();
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < POINT_N; i++) begin
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        total++;
        if ({got_a, got_b} !== {exp_vec(m0), exp_vec(m1)}) begin
          bad++; $display("FAIL win3_rally: dut0=%h dut1=%h expected=%h/%h", got_a, got_b, exp_vec(m0), exp_vec(m1));
        end
      end
    end
    total++;
    if ({b_game_over, b_score_p1, b_score_p2} !== {1'b1, 4'd3, 4'd2} || a_game_over !== 1'b0) begin
      bad++; $display("FAIL win3_over: go=%b p1=%0d p2=%0d dut0_go=%b expected 1/3/2/0", b_game_over, b_score_p1, b_score_p2, a_game_over);
    end
    run_to_play();
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    total++;
    if (b_score_p1 !== 4'd3 || a_score_p1 !== 4'd4) begin
      bad++; $display("FAIL win3_hold: dut1_p1=%0d dut0_p1=%0d expected 3/4", b_score_p1, a_score_p1);
    end
  endtask

  task automatic test_win_over();
    for (int k = 0; k < 20 && m0.p1 < 10; k++) begin
      run_to_play();
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      total++;
      if ({got_a, got_b} !== {exp_vec(m0), exp_vec(m1)}) begin
        bad++; $display("FAIL climb: dut0=%h dut1=%h expected=%h/%h", got_a, got_b, exp_vec(m0), exp_vec(m1));
      end
    end
    run_to_play();
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    total++;
    if (a_score_p1 !== 4'd11 || a_serve_dir !== 1'b1) begin
      bad++; $display("FAIL win_point: p1=%0d dir=%b expected 11/1", a_score_p1, a_serve_dir);
    end
    repeat (POINT_N) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    total++;
    if (a_game_over !== 1'b1 || a_sq_shown !== 1'b0) begin
      bad++; $display("FAIL game_over: go/sq=%b%b expected=10", a_game_over, a_sq_shown);
    end
    for (int t = 1; t <= 125; t++) begin
      cycle(1'b1, t == 50, 1'b0, 1'b0);
      total++;
      if ({got_a, got_b} !== {exp_vec(m0), exp_vec(m1)} || a_game_over !== 1'b1) begin
        bad++; $display("FAIL over_lockout: dut0=%h dut1=%h expected=%h/%h", got_a, got_b, exp_vec(m0), exp_vec(m1));
      end
    end
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    total++;
    if ({a_game_over, a_show_startup, a_score_p1, a_score_p2, a_serve_dir} !== {1'b0, 1'b1, 4'd0, 4'd0, 1'b0}) begin
      bad++; $display("FAIL over_exit: go=%b st=%b p1=%0d p2=%0d dir=%b expected 0/1/0/0/0",
                      a_game_over, a_show_startup, a_score_p1, a_score_p2, a_serve_dir);
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    bit key = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) key = ~key;
      cycle(1'($urandom_range(0, 1)), key, $urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0);
      total++;
      if ({got_a, got_b} !== {exp_vec(m0), exp_vec(m1)}) begin
        bad++; $display("FAIL random: dut0=%h dut1=%h expected=%h/%h", got_a, got_b, exp_vec(m0), exp_vec(m1));
      end
    end
  endtask

  task automatic test_async_reset();
    rst = 1'b1;
    @(negedge clk_0);
    rst = 1'b0;
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    run_to_play();
    total++;
    if (a_ball_run !== 1'b1) begin
      bad++; $display("FAIL reach_play: run=%b expected=1", a_ball_run);
    end
    clk_en = 1'b0;
    #3 rst = 1'b1;
    #1;
    total++;
    if (got_a !== RESET_VEC || got_b !== RESET_VEC) begin
      bad++; $display("FAIL async_reset: dut0=%h dut1=%h expected=%h", got_a, got_b, RESET_VEC);
    end
    #20 rst = 1'b0;
    clk_en = 1'b1;
    @(negedge clk_0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    total++;
    if (got_a !== RESET_VEC || {got_a, got_b} !== {exp_vec(m0), exp_vec(m1)}) begin
      bad++; $display("FAIL reset_exit: dut0=%h dut1=%h expected=%h", got_a, got_b, RESET_VEC);
    end
  endtask

  initial begin
    test_reset();
    test_key_hold();
    test_miss_left();
    test_both_miss();
    test_win3();
    test_win_over();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
